nrd_recomb8: RTL
================

# nrd_recomb8

Sequential signed Booth multiply-accumulate that performs the inverse of the 8-bit non-restoring divider. It takes a quotient, divisor and remainder and rebuilds `quo*divisor + rem`. Its primary use is as the reconstruction stage in divider self-checking datapaths: it is fed directly from the divider outputs and reports whether the reconstructed value is a legal 8-bit dividend. It is iterative, with a start/busy/done handshake and one Booth step per clock.

## Interface
Parameters:
- none. Widths are fixed to match the divider: 8-bit quotient, 7-bit divisor, 8-bit remainder.

Ports:
- `clk`  in  1  rising-edge clock, the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `quo`  in  8  signed quotient (multiplier).
- `divisor`  in  7  unsigned divisor, zero-extended to 8 bits (multiplicand M).
- `rem`  in  8  signed remainder, added after the multiply.
- `busy`  out  1  high from the accepting edge until the result edge.
- `done`  out  1  one-cycle pulse; result valid.
- `prod`  out  16  signed `quo*{1'b0,divisor} + sext(rem)`.
- `dividend`  out  8  `prod[7:0]`.
- `ovf`  out  1  high when `prod` is outside [-128, 127].

## Operation
- States: IDLE, RUN, DONE.
- **IDLE, start=1:**
  - Load A(9b)=0, Q=quo, Q_1=0, M=sext9({0,divisor}), R=rem, cnt=0.
  - Go to RUN. busy=1.
- **IDLE, start=0:** hold. Outputs keep their last result.
- **RUN (radix-2), one step per edge:**
  - Q[0],Q_1 = 01 → A+=M; 10 → A-=M; 00/11 → no add.
  - Then arithmetic shift right of {A,Q,Q_1}.
  - cnt++. After the 8th step go to DONE.
- **DONE edge:**
  - prod = {A[7:0],Q} + sext16(R).
  - ovf = (prod[15:7] not all-equal).
  - done=1, busy=0, go to IDLE.
- Arithmetic rules:
  - The 16-bit result cannot wrap. |quo*M| ≤ 16256, and 16256+128 < 32767.
  - A is 9 bits so that the radix-4 ±2M step never overflows.
- Inputs are sampled only on the accepting edge. Input changes during RUN are ignored.
- `start` while busy=1 or in DONE is ignored. It is not queued.
- divisor=0 → prod=sext(rem).
- **Reset (async, any state, including mid-operation):**
  - State=IDLE, all datapath registers 0.
  - busy=0, done=0, prod=0, dividend=0, ovf=0.
  - An aborted operation never produces done.

## Timing
- start high at accepting edge k.
- Radix-2:
  - Booth steps on edges k+1..k+8.
  - Result registered on edge k+9. done high for the cycle k+9..k+10.
  - busy high for cycles k..k+9 (from edge k to edge k+9).
- `start` held high during the done cycle is accepted at edge k+10. Back-to-back throughput is 1 op / 10 cycles.
- done and the outputs update on the same edge. prod/dividend/ovf stay stable until the next result edge or reset.

## Configuration
- `NRD_RECOMB_RADIX4_EN`: radix-4 Booth is compiled in.
  - Each RUN edge examines {Q[1],Q[0],Q_1} and adds 0, ±M or ±2M to A.
  - Then arithmetic shift right by 2. 4 steps.
  - Result edge k+5, done in cycle k+5..k+6, throughput 1 op / 6 cycles.
- Undefined: radix-2 as described, 8 steps, result edge k+9.
- Functional results are identical in both builds.

## Test plan
- quo=5, divisor=3, rem=2, start pulse → done exactly 9 edges later (5 with the macro); prod=17, dividend=8'h11, ovf=0, busy low after done.
- quo=-7 (8'hF9), divisor=3, rem=-1 (8'hFF) → prod=16'hFFEA (-22), dividend=8'hEA, ovf=0.
- quo=-128, divisor=127, rem=-128 → prod=16'hC000 (-16384), dividend=8'h00, ovf=1. Also quo=0, divisor=0, rem=-5 → prod=16'hFFFB, ovf=0.
- start held high continuously with the inputs from the first scenario → done pulses every 10 cycles (6 with the macro); changing quo during RUN does not change that op's result.
- start, then rst_n low for 1 cycle 4 edges later → busy, done, prod, ovf immediately 0; no done pulse follows; next start computes correctly.
- Random sweep of quo ∈ [-128,127], divisor ∈ [0,127], rem ∈ [-128,127] → prod equals the reference model `quo*divisor+rem`, and ovf matches the range check.

Source files
------------

// File: rtl/nrd_recomb8.sv
// rtl/nrd_recomb8.sv - sequential signed Booth multiply-accumulate rebuilding quo*divisor+rem
//
// Purpose: reconstructs the dividend from the outputs of the 8-bit non-restoring
//   divider. It runs one Booth step per clock behind a start/busy/done handshake.
//   Optional build macro: NRD_RECOMB_RADIX4_EN selects radix-4 Booth (4 steps).
//   The default build uses radix-2 Booth (8 steps).
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   request, sampled only in IDLE
//   quo      in   [7:0]  signed quotient (multiplier)
//   divisor  in   [6:0]  unsigned divisor (multiplicand, zero-extended)
//   rem      in   [7:0]  signed remainder, added after the multiply
//   busy     out  high from the accepting edge until the result edge
//   done     out  one-cycle result-valid pulse
//   prod     out  [15:0] signed quo*divisor + rem
//   dividend out  [7:0]  prod[7:0]
//   ovf      out  prod outside [-128, 127]
module nrd_recomb8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  quo,
  input  logic [6:0]  divisor,
  input  logic [7:0]  rem,
  output logic        busy,
  output logic        done,
  output logic [15:0] prod,
  output logic [7:0]  dividend,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

`ifdef NRD_RECOMB_RADIX4_EN
  localparam int         SHIFT    = 2;
  localparam logic [2:0] LAST_CNT = 3'd3;
`else
  localparam int         SHIFT    = 1;
  localparam logic [2:0] LAST_CNT = 3'd7;
`endif

  state_t      state, state_nxt;
  logic [8:0]  a;          // accumulator; 9 bits hold the partial sum in [-2M, 2M]
  logic [8:0]  m;          // multiplicand, zero-extended divisor
  logic [7:0]  q;          // multiplier, consumed from the bottom
  logic        q_1;        // Booth history bit
  logic [7:0]  r;          // remainder captured at accept
  logic [2:0]  cnt;
  logic [8:0]  addend;
  logic [8:0]  a_sum;
  logic [17:0] step_w;
  logic [15:0] prod_nxt;
  logic        last_step;

  // Booth recoding of the low multiplier bits into the accumulator addend.
  always_comb begin
    addend = 9'd0;
`ifdef NRD_RECOMB_RADIX4_EN
    case ({q[1], q[0], q_1})
      3'b001, 3'b010: addend = m;
      3'b011:         addend = m << 1;
      3'b100:         addend = -(m << 1);
      3'b101, 3'b110: addend = -m;
      default:        addend = 9'd0;
    endcase
`else
    case ({q[0], q_1})
      2'b01:   addend = m;
      2'b10:   addend = -m;
      default: addend = 9'd0;
    endcase
`endif
  end

  assign a_sum     = a + addend;
  assign step_w    = $signed({a_sum, q, q_1}) >>> SHIFT;
  assign last_step = (cnt == LAST_CNT);

  // After the final step {A,Q} holds the full product; it fits in 16 bits,
  // so A[8] is only a sign copy and is dropped here.
  assign prod_nxt  = {a[7:0], q} + {{8{r[7]}}, r};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign dividend = prod[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a     <= 9'd0;
      m     <= 9'd0;
      q     <= 8'd0;
      q_1   <= 1'b0;
      r     <= 8'd0;
      cnt   <= 3'd0;
      done  <= 1'b0;
      prod  <= 16'd0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a   <= 9'd0;
            m   <= {2'b00, divisor};
            q   <= quo;
            q_1 <= 1'b0;
            r   <= rem;
            cnt <= 3'd0;
          end
        end
        RUN: begin
          {a, q, q_1} <= step_w;
          cnt         <= cnt + 3'd1;
        end
        DONE: begin
          prod <= prod_nxt;
          // Fits in 8 signed bits only when bits 15..7 are all copies of the sign.
          ovf  <= !((&prod_nxt[15:7]) || !(|prod_nxt[15:7]));
        end
        default: ;
      endcase
    end
  end

endmodule
